bus_strobe_seq: RTL and testbench



---
 rtl/bus_seq_pkg.sv | 25 ++
 rtl/strobe_sync.sv | 20 ++
 rtl/bus_strobe_seq.sv | 145 ++++++++++++++
 tb/tb_bus_strobe_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_seq_pkg.sv
// Shared types and defaults for the bd-bus strobe sequencer.
package bus_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    WSETUP  = 3'd2,
    WPULSE  = 3'd3,
    WWAIT   = 3'd4,
    RECOVER = 3'd5
  } state_t;

  localparam int unsigned DEF_WR_SETUP = 1;
  localparam int unsigned DEF_WR_PULSE = 6;
  localparam int unsigned DEF_RECOVERY = 3;

  // True when every timing value fits in a w-bit timer.
  function automatic bit cnt_fits(int unsigned setup, int unsigned pulse,
                                  int unsigned rec, int unsigned w);
    longint unsigned lim;
    lim = longint'(1) << w;
    return (setup < lim) && (pulse < lim) && (rec < lim);
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// N-stage synchronizer for active-low strobes; resets to the inactive level.
module strobe_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '1;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/bus_strobe_seq.sv
// Sequences the buffered chip strobes brd_n/bwr_n on the shared bd bus:
// resynced reads, timed write pulses and a recovery gap after every access.
module bus_strobe_seq
  import bus_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WR_SETUP    = DEF_WR_SETUP,
  parameter int unsigned WR_PULSE    = DEF_WR_PULSE,
  parameter int unsigned RECOVERY    = DEF_RECOVERY,
  parameter int unsigned CNT_W       = 4
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic zrd_n,
  input  logic zwr_n,
  input  logic sel_w5300,
  input  logic sel_sl811,
  input  logic ovr_clr,
  output logic brd_n,
  output logic bwr_n,
  output logic busy,
  output logic overrun
);

  if (!cnt_fits(WR_SETUP, WR_PULSE, RECOVERY, CNT_W) ||
      SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_cfg
    $error("bus_strobe_seq: illegal SYNC_STAGES or CNT_W too small");
  end

  localparam logic [CNT_W-1:0] T_SETUP = CNT_W'(WR_SETUP);
  localparam logic [CNT_W-1:0] T_PULSE = CNT_W'(WR_PULSE);
  localparam logic [CNT_W-1:0] T_REC   = CNT_W'(RECOVERY);

  logic rd_s, wr_s, sel_r;
  state_t state, next;
  logic [CNT_W-1:0] timer, timer_nx;
  logic blocked, blocked_nx;
  logic seen, seen_nx;
  logic set_ovr;

  strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(fclk), .rst_n(rst_n), .d(zrd_n), .q(rd_s)
  );
  strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(fclk), .rst_n(rst_n), .d(zwr_n), .q(wr_s)
  );

  always_comb begin
    next       = state;
    timer_nx   = timer;
    blocked_nx = blocked;
    seen_nx    = seen;
    set_ovr    = 1'b0;
    case (state)
      IDLE: begin
        seen_nx = 1'b0;
        // After an illegal rd+wr overlap, nothing is served until both release.
        if (blocked) begin
          if (rd_s && wr_s) blocked_nx = 1'b0;
        end else if (sel_r) begin
          if (!rd_s && !wr_s) begin
            set_ovr    = 1'b1;
            blocked_nx = 1'b1;
          end else if (!rd_s) begin
            next = READ;
          end else if (!wr_s) begin
            if (WR_SETUP == 0) begin
              next     = WPULSE;
              timer_nx = T_PULSE;
            end else begin
              next     = WSETUP;
              timer_nx = T_SETUP;
            end
          end
        end
      end
      READ: begin
        if (rd_s) begin
          next     = RECOVER;
          timer_nx = T_REC;
        end
      end
      WSETUP, WPULSE: begin
        if (wr_s) begin
          set_ovr  = 1'b1;
          next     = RECOVER;
          timer_nx = T_REC;
        end else if (timer <= 1) begin
          next     = (state == WSETUP) ? WPULSE : WWAIT;
          timer_nx = (state == WSETUP) ? T_PULSE : '0;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      WWAIT: begin
        if (wr_s) begin
          next     = RECOVER;
          timer_nx = T_REC;
        end
      end
      RECOVER: begin
        if (sel_r && (!rd_s || !wr_s)) seen_nx = 1'b1;
        if (timer <= 1) begin
          next     = IDLE;
          timer_nx = '0;
          seen_nx  = 1'b0;
          // A strobe that came and went entirely inside the gap was dropped.
          if (seen && rd_s && wr_s) set_ovr = 1'b1;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      default: begin
        next     = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      blocked <= 1'b0;
      seen    <= 1'b0;
      sel_r   <= 1'b0;
      brd_n   <= 1'b1;
      bwr_n   <= 1'b1;
      overrun <= 1'b0;
    end else begin
      state   <= next;
      timer   <= timer_nx;
      blocked <= blocked_nx;
      seen    <= seen_nx;
      sel_r   <= sel_w5300 | sel_sl811;
      brd_n   <= (next != READ);
      bwr_n   <= (next != WPULSE);
      if (set_ovr)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bus_strobe_seq.sv
// Scoreboard bench for bus_strobe_seq: expected {brd_n,bwr_n,busy,overrun} per cycle.
module tb_bus_strobe_seq;

  logic fclk = 1'b0;
  logic rst_n, zrd_n, zwr_n, sel_w5300, sel_sl811, ovr_clr;
  logic brd_n, bwr_n, busy, overrun;
  logic [3:0] obs;
  logic [3:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  always #5 fclk = ~fclk;

  bus_strobe_seq dut (
    .fclk(fclk), .rst_n(rst_n), .zrd_n(zrd_n), .zwr_n(zwr_n),
    .sel_w5300(sel_w5300), .sel_sl811(sel_sl811), .ovr_clr(ovr_clr),
    .brd_n(brd_n), .bwr_n(bwr_n), .busy(busy), .overrun(overrun)
  );

  assign obs = {brd_n, bwr_n, busy, overrun};

  always @(negedge fclk) begin
    if (rst_n === 1'b1) begin
      tests++;
      if (brd_n === 1'b0 && bwr_n === 1'b0) begin
        fails++;
        $display("FAIL invariant t=%0t brd_n=%b bwr_n=%b want not both 0", $time, brd_n, bwr_n);
      end
    end
  end

  task automatic test_reset();
    logic [3:0] e;
    exp_q.push_back(4'b1100);
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_hold got %b want %b", obs, e);
    end
    rst_n = 1'b1;
    exp_q.push_back(4'b1100);
    @(posedge fclk); @(negedge fclk);
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_release got %b want %b", obs, e);
    end
  endtask

  task automatic test_read();
    logic [3:0] e;
    sel_w5300 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      zrd_n = !(c <= 20);
      exp_q.push_back({!(c >= 3 && c <= 22), 1'b1, (c >= 3 && c <= 25), 1'b0});
      @(posedge fclk); @(negedge fclk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL read c=%0d got %b want %b", c, obs, e);
      end
    end
    sel_w5300 = 1'b0;
  endtask

  task automatic test_write();
    logic [3:0] e;
    sel_sl811 = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      zwr_n = !(c <= 15);
      exp_q.push_back({1'b1, !(c >= 4 && c <= 9), (c >= 3 && c <= 20), 1'b0});
      @(posedge fclk); @(negedge fclk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL write c=%0d got %b want %b", c, obs, e);
      end
    end
    sel_sl811 = 1'b0;
  endtask

  task automatic test_short_write();
    logic [3:0] e;
    sel_w5300 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      zwr_n   = !(c <= 2);
      ovr_clr = (c == 11);
      exp_q.push_back({1'b1, !(c == 4), (c >= 3 && c <= 7), (c >= 5 && c <= 10)});
      @(posedge fclk); @(negedge fclk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL short_write c=%0d got %b want %b", c, obs, e);
      end
    end
    ovr_clr   = 1'b0;
    sel_w5300 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    sel_w5300 = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      zrd_n = !(c <= 5 || (c >= 7 && c <= 14));
      exp_q.push_back({!((c >= 3 && c <= 7) || (c >= 12 && c <= 16)), 1'b1,
                       ((c >= 3 && c <= 10) || (c >= 12 && c <= 19)), 1'b0});
      @(posedge fclk); @(negedge fclk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL back_to_back c=%0d got %b want %b", c, obs, e);
      end
    end
    sel_w5300 = 1'b0;
  endtask

  task automatic test_lost_in_recover();
    logic [3:0] e;
    sel_w5300 = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      zrd_n   = !(c <= 5 || c == 8);
      ovr_clr = (c == 14);
      exp_q.push_back({!(c >= 3 && c <= 7), 1'b1, (c >= 3 && c <= 10), (c >= 11 && c <= 13)});
      @(posedge fclk); @(negedge fclk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL lost_in_recover c=%0d got %b want %b", c, obs, e);
      end
    end
    ovr_clr   = 1'b0;
    sel_w5300 = 1'b0;
  endtask

  task automatic test_illegal();
    logic [3:0] e;
    sel_sl811 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      zrd_n   = !(c <= 6);
      zwr_n   = !(c <= 10);
      ovr_clr = (c == 3 || c == 15);
      exp_q.push_back({1'b1, 1'b1, 1'b0, (c >= 3 && c <= 14)});
      @(posedge fclk); @(negedge fclk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL illegal c=%0d got %b want %b", c, obs, e);
      end
    end
    ovr_clr   = 1'b0;
    sel_sl811 = 1'b0;
  endtask

  task automatic test_foreign();
    logic [3:0] e;
    for (int c = 1; c <= 16; c++) begin
      zrd_n = !(c <= 6);
      zwr_n = !(c >= 8 && c <= 12);
      exp_q.push_back(4'b1100);
      @(posedge fclk); @(negedge fclk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL foreign c=%0d got %b want %b", c, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [3:0] e;
    sel_w5300 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      zwr_n = 1'b0;
      exp_q.push_back({1'b1, !(c >= 4), (c >= 3), 1'b0});
      @(posedge fclk); @(negedge fclk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_mid_pre c=%0d got %b want %b", c, obs, e);
      end
    end
    #2 rst_n = 1'b0;
    exp_q.push_back(4'b1100);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_async got %b want %b", obs, e);
    end
    zwr_n     = 1'b1;
    sel_w5300 = 1'b0;
    @(negedge fclk);
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      exp_q.push_back(4'b1100);
      @(posedge fclk); @(negedge fclk);
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_mid_post c=%0d got %b want %b", c, obs, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; zrd_n = 1'b1; zwr_n = 1'b1;
    sel_w5300 = 1'b0; sel_sl811 = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(negedge fclk);
    test_reset();
    test_read();
    test_write();
    test_short_write();
    test_back_to_back();
    test_lost_in_recover();
    test_illegal();
    test_foreign();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
